// File: rtl/reg_file_param.sv
// Parametrised register file with NREAD combinational read ports, one write port and a pending scoreboard.
// Latency: reads are combinational; writes and reservations are visible after the clock edge; NREGS-edge zero sweep after reset.
// Backpressure: none accepted; writes/reservations are dropped while init_busy is high. Optional macro RF_BYPASS_EN: write-to-read bypass.
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cu_rdwrite,
    input  logic [AW-1:0]         rd_addr,
    input  logic [XLEN-1:0]       rd_in,
    input  logic                  cu_rdreserve,
    input  logic [AW-1:0]         res_addr,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_pending,
    output logic                  init_busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     idx;
    logic              sweep_we;
    logic              is_ready;
    logic              wr_ok;
    logic              rsv_ok;
    logic [NREGS-1:0]  pending;
    logic [XLEN-1:0]   mem [NREGS];

    logic [AW-1:0]     ra;
    logic [XLEN-1:0]   rd_val;
    logic              pd_val;

    // FSM state register; reset always restarts the sweep
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR on the edge that clears the last register
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (idx == AW'(NREGS - 1)) state_d = READY;
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        sweep_we  = (state_q == CLEAR);
        init_busy = (state_q == CLEAR);
        is_ready  = (state_q == READY);
    end

    // Sweep index advances once per edge while clearing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (sweep_we) begin
            idx <= idx + AW'(1);
        end
    end

    // Register 0 is hard-wired when ZERO_REG is set, so its writes and reservations are dropped
    always_comb begin
        wr_ok  = is_ready && cu_rdwrite   && !((ZERO_REG != 0) && (rd_addr  == '0));
        rsv_ok = is_ready && cu_rdreserve && !((ZERO_REG != 0) && (res_addr == '0));
    end

    // Storage array has no reset; the sweep supplies the initial zeros
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[rd_addr] <= rd_in;
        end
    end

    // Pending scoreboard: a write clears, a reservation sets, and a same-address reservation wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[rd_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                pending[res_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports, forced to zero during the sweep and for the zero register
    always_comb begin
        rs_data    = '0;
        rs_pending = '0;
        ra         = '0;
        rd_val     = '0;
        pd_val     = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            ra     = rs_addr[k*AW +: AW];
            rd_val = mem[ra];
            pd_val = pending[ra];
`ifdef RF_BYPASS_EN
            if (wr_ok && (rd_addr == ra)) begin
                rd_val = rd_in;
                pd_val = rsv_ok && (res_addr == ra);
            end
`endif
            if (!is_ready || ((ZERO_REG != 0) && (ra == '0))) begin
                rd_val = '0;
                pd_val = 1'b0;
            end
            rs_data[k*XLEN +: XLEN] = rd_val;
            rs_pending[k]           = pd_val;
        end
    end

endmodule
